uart_rx: RTL and testbench
==========================

# uart_rx

Serial-to-parallel receiver for the 8N1 UART link whose transmit side drives idle-high, one low start bit, 8 data bits LSB first and one high stop bit. It samples the asynchronous `RX_in` line on the system clock, recovers one byte per frame and presents it with a one-cycle `data_valid` strobe. It also flags false starts and framing errors. It sits between the board pin and the byte consumer, for example a FIFO or command parser, and uses the same bit-period parameter as the transmitter.

## Interface
- `clock_per_bit`, default 13021: system clocks per bit, equal to clk / baud. Legal range is 4 or more.
- `clk` input, 1 bit: system clock; everything is on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `RX_in` input, 1 bit: serial line, asynchronous to `clk`, idle high.
- `data_out` output, 8 bits: last correctly received byte; held until the next good frame.
- `data_valid` output, 1 bit: one-cycle pulse when `data_out` has just been updated.
- `frame_err` output, 1 bit: one-cycle pulse when the stop bit is sampled low.
- `RX_busy` output, 1 bit: high from start-bit detection until the state machine returns to IDLE.

## Operation
- `RX_in` passes through a 2-flop synchronizer; all logic uses the synchronized value `rx_s`.
- States and transitions:
  - IDLE:
    - Counter and bit index are cleared.
    - `rx_s == 0` moves to START and sets `RX_busy` to 1.
  - START:
    - At the mid-bit point, `rx_s == 1` is a false start: go to IDLE with no pulse.
    - Otherwise clear the counter and go to DATA.
  - DATA:
    - Sample each bit at the full-period point; shift it into bit [index]; index counts 0..7.
    - After bit 7 go to STOP.
  - STOP:
    - Sample one period after bit 7.
    - If high: load `data_out` from the shift register, pulse `data_valid`, go to IDLE.
    - If low: pulse `frame_err`, leave `data_out` unchanged, go to BREAK.
  - BREAK: wait for `rx_s == 1`, then go to IDLE. This prevents a held-low line from being taken as repeated starts.
  - Any unused encoding goes to IDLE.
- `RX_busy` falls in the same cycle the state returns to IDLE.
- `data_valid` and `frame_err` are never high in the same cycle.
- A new start bit is accepted on the first cycle back in IDLE. Back-to-back frames, stop bit followed immediately by a start bit, must be received without loss.

## Timing
- Reset state: state = IDLE, counter and index = 0, both synchronizer flops = 1.
- Output reset values: `data_out` = 8'h00; `data_valid`, `frame_err` and `RX_busy` = 0.
- Reset asserted mid-frame aborts the frame with no pulse. After release, the block waits for a fresh falling edge.
- half = floor(`clock_per_bit` / 2).
- The start bit is sampled at count == half−1 after entering START.
- Data bit k (k = 0..7) is sampled `clock_per_bit` × (k+1) cycles after the start-bit sample.
- The stop bit is sampled `clock_per_bit` × 9 cycles after the start-bit sample.
- `data_valid` or `frame_err` is registered and appears the cycle after the stop sample.
- Latency from the `RX_in` falling edge to `data_valid` is 2 (synchronizer) + 1 (IDLE detect) + half + 9×`clock_per_bit` + 1 cycles. The bench checks this exact value.
- The counter must be wide enough for `clock_per_bit` − 1; use a 32-bit integer or $clog2 sizing. It wraps only through explicit clearing.

## Configuration
- Macro: `UART_RX_MAJORITY_EN`.
- When defined:
  - Each start, data and stop decision is a 2-of-3 majority of `rx_s` at sample point −1, 0 and +1.
  - The decision is made at sample point +1, which shifts all outputs one cycle later.
- When undefined: a single sample at the sample point; latency as stated under Timing.

## Structure
- Package `uart_pkg` holds:
  - the state enum: IDLE, START, DATA, STOP, BREAK;
  - `UART_DATA_W` = 8;
  - the default `CLOCK_PER_BIT` = 13021, shared with the transmitter.
- Sub-module `uart_sync2`: generic 2-flop synchronizer with a reset value parameter, instantiated for `RX_in` with reset value 1.

## Test plan
Use `clock_per_bit` = 16 for all scenarios.
- **Single frame:** drive an 8N1 frame with byte 8'hA5. Expect exactly one `data_valid` pulse with `data_out` = 8'hA5, at the stated cycle count.
- **Back-to-back:** frames 8'h00, 8'hFF, 8'h3C with zero idle gap. Expect three `data_valid` pulses in order with correct bytes and no `frame_err`.
- **False start:** low glitch of 5 cycles. Expect no pulse, `RX_busy` back to 0 within 16 cycles, and `data_out` unchanged.
- **Framing error:** frame 8'h55 with the stop bit low, then the line held low for 40 cycles. Expect one `frame_err` pulse, no `data_valid`, `data_out` holding its old value, and the next good frame 8'h12 received correctly.
- **Reset mid-frame:** assert `rst_n` low during data bit 4. Expect all outputs at reset values immediately, no pulse, and the next frame 8'hC3 received correctly.
- **With `UART_RX_MAJORITY_EN`:** frame 8'h81 with a one-cycle inverted glitch at each mid-bit. Expect `data_out` = 8'h81 and `data_valid` exactly one cycle later than the baseline.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and bit period.
// Used by uart_rx and the matching transmitter.
package uart_pkg;

  localparam int UART_DATA_W   = 8;
  localparam int CLOCK_PER_BIT = 13021;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer for a single asynchronous bit.
// RST_VAL sets both flops at reset so an idle line reads correctly.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with false-start, framing-error and break handling.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
import uart_pkg::*;

module uart_rx #(
  parameter int clock_per_bit = CLOCK_PER_BIT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   RX_in,
  output logic [UART_DATA_W-1:0] data_out,
  output logic                   data_valid,
  output logic                   frame_err,
  output logic                   RX_busy
);

  localparam int HALF = clock_per_bit / 2;
  localparam int CW   = $clog2(clock_per_bit);
  localparam int IW   = $clog2(UART_DATA_W);
`ifdef UART_RX_MAJORITY_EN
  localparam int START_PT = HALF;
`else
  localparam int START_PT = HALF - 1;
`endif
  localparam logic [CW-1:0] START_LAST = CW'(START_PT);
  localparam logic [CW-1:0] BIT_LAST   = CW'(clock_per_bit - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(UART_DATA_W - 1);

  rx_state_e              state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [IW-1:0]          idx, idx_nxt;
  logic [UART_DATA_W-1:0] shreg, shreg_nxt;
  logic                   good_q, good_nxt;
  logic                   bad_q, bad_nxt;
  logic                   rx_s;
  logic                   bit_v;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (RX_in),
    .q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= 2'b11;
    else        hist <= {hist[0], rx_s};
  end

  // Decision one cycle late: hist[1]=point-1, hist[0]=point, rx_s=point+1
  assign bit_v = maj3(hist[1], hist[0], rx_s);
`else
  assign bit_v = rx_s;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    good_nxt  = 1'b0;
    bad_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (cnt == START_LAST) begin
          cnt_nxt   = '0;
          state_nxt = bit_v ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt        = '0;
          shreg_nxt[idx] = bit_v;
          idx_nxt        = idx + 1'b1;
          if (idx == IDX_LAST) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (bit_v) begin
            good_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            bad_nxt   = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        // Hold off until the line idles so a stuck-low line is one error
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
      good_q <= 1'b0;
      bad_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      shreg  <= shreg_nxt;
      good_q <= good_nxt;
      bad_q  <= bad_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= good_q;
      frame_err  <= bad_q;
      if (good_q) data_out <= shreg;
    end
  end

  assign RX_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit.
// Stimulus pushes expected pulses; a negedge monitor pops and compares.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 2 + 1 + HALF + 9 * CPB + 1 + 1;
`else
  localparam int LAT = 2 + 1 + HALF + 9 * CPB + 1;
`endif
  localparam int FRAME = 10 * CPB;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       RX_in = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       RX_busy;

  uart_rx #(.clock_per_bit(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX_in      (RX_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .RX_busy    (RX_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [7:0] d;
    int         at;
  } exp_t;

  exp_t       sb[$];
  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] last_good   = 8'h00;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (data_valid || frame_err)) begin
      check("pulse_exclusive", {31'b0, data_valid & frame_err}, 32'd0);
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: dv=%0b fe=%0b data=%0h cycle %0d",
                 data_valid, frame_err, data_out, cyc);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", {31'b0, frame_err}, {31'b0, e.err});
        check("pulse_data", {24'b0, data_out}, {24'b0, e.d});
        check("pulse_cycle", cyc, e.at);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      RX_in = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input bit glitch, input int ncyc);
    logic [9:0] bits;
    int n;
    bits = {stop_b, d, 1'b0};
    n = 0;
    for (int j = 0; j < 10; j++) begin
      for (int c = 0; c < CPB; c++) begin
        if (n < ncyc) begin
          @(posedge clk);
          #1;
          if (n == 0 && ncyc == FRAME) begin
            if (stop_b) begin
              sb.push_back('{err: 1'b0, d: d, at: cyc + LAT});
              last_good = d;
            end else begin
              sb.push_back('{err: 1'b1, d: last_good, at: cyc + LAT});
            end
          end
          RX_in = bits[j] ^ (glitch && c == HALF);
          n++;
        end
      end
    end
  endtask

  initial begin
    int t0;
    rst_n = 1'b0;
    RX_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", {24'b0, data_out}, 32'h00);
    check("rst_data_valid", {31'b0, data_valid}, 32'd0);
    check("rst_frame_err", {31'b0, frame_err}, 32'd0);
    check("rst_busy", {31'b0, RX_busy}, 32'd0);
    rst_n = 1'b1;
    idle(5);

    send_frame(8'hA5, 1'b1, 1'b0, FRAME);
    idle(20);

    send_frame(8'h00, 1'b1, 1'b0, FRAME);
    send_frame(8'hFF, 1'b1, 1'b0, FRAME);
    send_frame(8'h3C, 1'b1, 1'b0, FRAME);
    idle(20);

    @(posedge clk);
    #1;
    t0 = cyc;
    RX_in = 1'b0;
    idle(0);
    for (int i = 1; i < 5; i++) begin
      @(posedge clk);
      #1;
      RX_in = 1'b0;
    end
    while (cyc < t0 + 16) idle(1);
    check("false_start_busy", {31'b0, RX_busy}, 32'd0);
    check("false_start_data", {24'b0, data_out}, {24'b0, last_good});
    idle(10);

    send_frame(8'h55, 1'b0, 1'b0, FRAME);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      RX_in = 1'b0;
    end
    idle(20);
    send_frame(8'h12, 1'b1, 1'b0, FRAME);
    idle(20);

    send_frame(8'hE7, 1'b1, 1'b0, 5 * CPB + 8);
    rst_n = 1'b0;
    RX_in = 1'b1;
    #1;
    check("midrst_data_out", {24'b0, data_out}, 32'h00);
    check("midrst_data_valid", {31'b0, data_valid}, 32'd0);
    check("midrst_frame_err", {31'b0, frame_err}, 32'd0);
    check("midrst_busy", {31'b0, RX_busy}, 32'd0);
    last_good = 8'h00;
    idle(3);
    rst_n = 1'b1;
    idle(10);
    send_frame(8'hC3, 1'b1, 1'b0, FRAME);
    idle(20);

`ifdef UART_RX_MAJORITY_EN
    send_frame(8'h81, 1'b1, 1'b1, FRAME);
    idle(20);
`endif

    for (int i = 0; i < 400 && sb.size() != 0; i++) idle(1);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_pulse: got none want err=%0b data=%0h at %0d",
               e.err, e.d, e.at);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
